clkdiv_ctrl: RTL and testbench

- Run/stop and rate-configuration controller for the team's divided-clock generator; owns the divide counter and produces the `scaledclk` square wave plus a one-cycle rising-edge pulse.
- Accepts runtime divide-ratio changes over a valid/ready handshake.
- Applies new ratios only on a toggle boundary, so no output half-period is ever truncated.
- Sits between the control FSM (stopwatch/timer logic) and every consumer of the slow clock/tick.

---
 rtl/clkdiv_ctrl.sv | 69 ++++++
 tb/tb_clkdiv_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: run/stop and rate controller producing scaledclk and a rise pulse.
// Define CLKDIV_CTRL_TICK_COUNT_EN to add the tick_count output.
module clkdiv_ctrl #(
   parameter int DIV_W = 16,
   parameter int DEFAULT_DIV = 100
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             start,
   input  logic             stop,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             scaledclk,
   output logic             rise_pulse,
   output logic             running,
`ifdef CLKDIV_CTRL_TICK_COUNT_EN
   output logic [15:0]      tick_count,
`endif
   output logic [DIV_W-1:0] active_div
);
   typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
   state_t state;
   logic [DIV_W-1:0] counter, pend_div, cfg_clamped;
   logic pend_full, xfer, boundary;
   assign cfg_ready = !pend_full;
   assign xfer = cfg_valid && cfg_ready;
   assign cfg_clamped = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
   assign boundary = (state != IDLE) && enable && (counter == active_div - DIV_W'(1));
   assign running = (state != IDLE);
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         counter <= '0;
         scaledclk <= 1'b0;
         rise_pulse <= 1'b0;
         active_div <= DIV_W'(DEFAULT_DIV);
         pend_div <= '0;
         pend_full <= 1'b0;
      end else begin
         rise_pulse <= 1'b0;
         if (xfer && state == IDLE) active_div <= cfg_clamped;
         if (xfer && state != IDLE) begin
            pend_div <= cfg_clamped;
            pend_full <= 1'b1;
         end
         if (state == IDLE && start && !stop) state <= RUN;
         if (state == RUN && stop) state <= STOPPING;
         // Pending ratios land only here, so a half-period is never cut short.
         if (boundary) begin
            counter <= '0;
            scaledclk <= !scaledclk;
            rise_pulse <= !scaledclk;
            if (pend_full) begin
               active_div <= pend_div;
               pend_full <= 1'b0;
            end
            if (state == STOPPING && scaledclk) state <= IDLE;
         end else if (state != IDLE && enable) counter <= counter + DIV_W'(1);
      end
   end
`ifdef CLKDIV_CTRL_TICK_COUNT_EN
   always_ff @(posedge clock) begin
      if (reset || (state == IDLE && start && !stop)) tick_count <= '0;
      else if (boundary && !scaledclk) tick_count <= tick_count + 16'd1;
   end
`endif
endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb_clkdiv_ctrl: directed and randomized checks of clkdiv_ctrl against a
// remaining-cycles reference model.
module tb_clkdiv_ctrl;
   logic clock = 0, reset = 1, enable = 1, start = 0, stop = 0, cfg_valid = 0;
   logic [15:0] cfg_div = 0;
   logic cfg_ready, scaledclk, rise_pulse, running;
   logic [15:0] active_div;
`ifdef CLKDIV_CTRL_TICK_COUNT_EN
   logic [15:0] tick_count;
`endif
   int checks = 0, failures = 0;
   int m_mode, m_left, m_div, m_ticks;
   bit m_clk, m_rise;
   int pend[$];

   clkdiv_ctrl dut (
      .clock(clock), .reset(reset), .enable(enable), .start(start), .stop(stop),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_div(cfg_div),
      .scaledclk(scaledclk), .rise_pulse(rise_pulse), .running(running),
`ifdef CLKDIV_CTRL_TICK_COUNT_EN
      .tick_count(tick_count),
`endif
      .active_div(active_div)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Model: m_left counts enabled cycles remaining in the current half-period.
   task automatic model_step();
      bit xfer, edge_;
      int cdiv;
      if (reset) begin
         m_mode = 0; m_div = 100; m_left = 100; m_clk = 0; m_rise = 0; m_ticks = 0;
         pend.delete();
         return;
      end
      xfer = cfg_valid && pend.size() == 0;
      cdiv = (cfg_div == 0) ? 1 : int'(cfg_div);
      edge_ = m_mode != 0 && enable && m_left == 1;
      m_rise = 0;
      if (m_mode != 0 && enable && !edge_) m_left--;
      if (edge_) begin
         m_clk = !m_clk;
         m_rise = m_clk;
         if (m_rise) m_ticks = (m_ticks + 1) % 65536;
         if (pend.size() != 0) m_div = pend.pop_front();
         m_left = m_div;
      end
      if (xfer) begin
         if (m_mode == 0) m_div = cdiv;
         else pend.push_back(cdiv);
      end
      if (m_mode == 0 && start && !stop) begin
         m_mode = 1; m_left = m_div; m_ticks = 0;
      end else if (m_mode == 1 && stop) m_mode = 2;
      else if (m_mode == 2 && edge_ && !m_clk) m_mode = 0;
   endtask

   task automatic cyc();
      model_step();
      @(posedge clock);
      #1;
      chk("scaledclk", 32'(scaledclk), 32'(m_clk));
      chk("rise_pulse", 32'(rise_pulse), 32'(m_rise));
      chk("running", 32'(running), 32'(m_mode != 0));
      chk("active_div", 32'(active_div), 32'(m_div));
      chk("cfg_ready", 32'(cfg_ready), 32'(pend.size() == 0));
`ifdef CLKDIV_CTRL_TICK_COUNT_EN
      chk("tick_count", 32'(tick_count), 32'(m_ticks));
`endif
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic pulse_start();
      start = 1; cyc(); start = 0;
   endtask

   task automatic pulse_stop();
      stop = 1; cyc(); stop = 0;
   endtask

   task automatic cfg(input logic [15:0] d);
      cfg_div = d; cfg_valid = 1; cyc(); cfg_valid = 0;
   endtask

   task automatic do_reset();
      reset = 1; cyc(); reset = 0;
   endtask

   task automatic wait_level(input string tag, input logic lvl);
      int i;
      for (i = 0; i < 60 && scaledclk !== lvl; i++) cyc();
      chk(tag, 32'(scaledclk), 32'(lvl));
   endtask

   initial begin
      int n, rises;
      do_reset();
      do_reset();
      chk("rst_scaledclk", 32'(scaledclk), 0);
      chk("rst_running", 32'(running), 0);
      chk("rst_active_div", 32'(active_div), 100);
      chk("rst_cfg_ready", 32'(cfg_ready), 1);
      // Default ratio: first rise 100 cycles after RUN entry, two rises in 400.
      pulse_start();
      n = 0; rises = 0;
      for (int i = 1; i <= 400; i++) begin
         cyc();
         if (rise_pulse) begin
            rises++;
            if (n == 0) n = i;
         end
      end
      chk("first_rise_cycle", 32'(n), 100);
      chk("rises_in_400", 32'(rises), 2);
      // IDLE config goes straight to active_div, then 3/3 period.
      do_reset();
      cfg(3);
      chk("idle_cfg_3", 32'(active_div), 3);
      pulse_start();
      run(14);
      // Mid-run change from 4 to 2, then 0 clamps to 1.
      do_reset();
      cfg(4);
      pulse_start();
      run(6);
      cfg(2);
      chk("ready_low_after_accept", 32'(cfg_ready), 0);
      chk("div_still_4", 32'(active_div), 4);
      run(12);
      chk("div_now_2", 32'(active_div), 2);
      cfg(0);
      run(6);
      chk("clamp_div_1", 32'(active_div), 1);
      run(6);
      // Stop while high, then stop while low.
      do_reset();
      cfg(5);
      pulse_start();
      wait_level("wait_high", 1);
      cyc();
      pulse_stop();
      run(10);
      chk("stop_hi_idle", 32'(running), 0);
      run(12);
      chk("stop_hi_clk", 32'(scaledclk), 0);
      pulse_start();
      run(2);
      pulse_stop();
      run(4);
      chk("stop_lo_still_run", 32'(running), 1);
      run(16);
      chk("stop_lo_idle", 32'(running), 0);
      // Enable gap of 7 cycles mid half-period.
      pulse_start();
      run(2);
      enable = 0; run(7); enable = 1;
      run(20);
      // Reset mid-run with a pending config.
      cfg(7);
      do_reset();
      chk("midrst_clk", 32'(scaledclk), 0);
      chk("midrst_running", 32'(running), 0);
      chk("midrst_div", 32'(active_div), 100);
      chk("midrst_ready", 32'(cfg_ready), 1);
`ifdef CLKDIV_CTRL_TICK_COUNT_EN
      cfg(1);
      pulse_start();
      run(20);
      chk("tick_20", 32'(tick_count), 10);
      pulse_stop();
      run(4);
      pulse_start();
      chk("tick_restart", 32'(tick_count), 0);
`endif
      // Randomized traffic; cfg_div stays stable while an offer is pending.
      do_reset();
      cfg(2);
      for (int i = 0; i < 3000; i++) begin
         enable = ($urandom_range(0, 9) != 0);
         start = ($urandom_range(0, 40) == 0);
         stop = ($urandom_range(0, 60) == 0);
         reset = ($urandom_range(0, 500) == 0);
         if (!(cfg_valid && pend.size() != 0)) begin
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_div = 16'($urandom_range(0, 6));
         end
         cyc();
      end
      reset = 0; start = 0; stop = 0; cfg_valid = 0; enable = 1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
